// File: rtl/immgen_pipe.sv
// Two-stage RV immediate generator: stage 1 decodes the opcode into a format,
// stage 2 assembles the I/S/B/U/J immediate and extends it to XLEN.
module immgen_pipe #(
    parameter int XLEN        = 64,
    parameter int SIGN_EXT    = 1,
    parameter int BYTE_OFFSET = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    // Stage 1 holds instr[31:7] plus the decoded format.
    logic        r_s1_valid;
    logic [31:7] r_s1_bits;
    fmt_e        r_s1_fmt;

    // Stage 2 is the output register set.
    logic            r_s2_valid;
    logic [XLEN-1:0] r_imm;
    fmt_e            r_fmt;
    logic            r_illegal;

    logic            w_s2_load;
    logic            w_s1_open;
    fmt_e            w_dec_fmt;
    logic [XLEN-1:0] w_asm_imm;
    logic [31:7]     w_ins;
    logic [11:0]     w_i_raw;
    logic [11:0]     w_s_raw;
    logic [12:0]     w_b_raw13;
    logic [11:0]     w_b_raw12;
    logic [31:0]     w_u_raw;
    logic [20:0]     w_j_raw21;
    logic [19:0]     w_j_raw20;

    // valid/ready: a beat transfers on an edge where valid && ready. Stage 2
    // loads when it is empty or its content is being taken; stage 1 advances
    // whenever stage 2 loads, so in_ready depends only on registered state
    // and out_ready, never on in_valid. flush overrides every transfer.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_open = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_open;

    always_comb begin
        w_dec_fmt = FMT_NONE;
        unique case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: w_dec_fmt = FMT_I;
            7'b0011011: w_dec_fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
            7'b0100011: w_dec_fmt = FMT_S;
            7'b1100011: w_dec_fmt = FMT_B;
            7'b0110111, 7'b0010111: w_dec_fmt = FMT_U;
            7'b1101111: w_dec_fmt = FMT_J;
            default:    w_dec_fmt = FMT_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_bits  <= '0;
            r_s1_fmt   <= FMT_NONE;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_open) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_bits <= instr[31:7];
                r_s1_fmt  <= w_dec_fmt;
            end
        end
    end

    // Field scatter uses the original instruction bit numbers.
    assign w_ins     = r_s1_bits;
    assign w_i_raw   = w_ins[31:20];
    assign w_s_raw   = {w_ins[31:25], w_ins[11:7]};
    assign w_b_raw13 = {w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
    assign w_b_raw12 = w_b_raw13[12:1];
    assign w_u_raw   = {w_ins[31:12], 12'b0};
    assign w_j_raw21 = {w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
    assign w_j_raw20 = w_j_raw21[20:1];

    always_comb begin
        w_asm_imm = '0;
        unique case (r_s1_fmt)
            FMT_I: w_asm_imm = (SIGN_EXT != 0) ? XLEN'($signed(w_i_raw)) : XLEN'(w_i_raw);
            FMT_S: w_asm_imm = (SIGN_EXT != 0) ? XLEN'($signed(w_s_raw)) : XLEN'(w_s_raw);
            FMT_B: begin
                if (BYTE_OFFSET != 0)
                    w_asm_imm = (SIGN_EXT != 0) ? XLEN'($signed(w_b_raw13)) : XLEN'(w_b_raw13);
                else
                    w_asm_imm = (SIGN_EXT != 0) ? XLEN'($signed(w_b_raw12)) : XLEN'(w_b_raw12);
            end
            // U already spans 32 bits; on RV64 it is architecturally sign-extended.
            FMT_U: w_asm_imm = XLEN'($signed(w_u_raw));
            FMT_J: begin
                if (BYTE_OFFSET != 0)
                    w_asm_imm = (SIGN_EXT != 0) ? XLEN'($signed(w_j_raw21)) : XLEN'(w_j_raw21);
                else
                    w_asm_imm = (SIGN_EXT != 0) ? XLEN'($signed(w_j_raw20)) : XLEN'(w_j_raw20);
            end
            default: w_asm_imm = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_imm      <= '0;
            r_fmt      <= FMT_NONE;
            r_illegal  <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_imm     <= w_asm_imm;
                r_fmt     <= r_s1_fmt;
                r_illegal <= (r_s1_fmt == FMT_NONE);
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign imm       = r_imm;
    assign fmt       = r_fmt;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: three configurations share one input stream and are
// compared against an arithmetic reference model through an expected queue.
module tb_immgen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;

    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  ill_v;
    logic [2:0]  fmt_a, fmt_b, fmt_c;
    logic [63:0] imm_a, imm_c;
    logic [31:0] imm_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int dut_drained = 0;
    bit acc = 0;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } res_t;

    typedef struct {
        res_t r0;
        res_t r1;
        res_t r2;
        int   t;
    } entry_t;

    entry_t exp_q[$];

    // a: XLEN64 sign-ext byte-offset; b: XLEN32 zero-ext halfword; c: XLEN64 sign-ext halfword
    immgen_pipe #(.XLEN(64), .SIGN_EXT(1), .BYTE_OFFSET(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .instr(instr), .out_valid(out_valid_v[0]), .out_ready(out_ready), .imm(imm_a),
        .fmt(fmt_a), .illegal(ill_v[0]));
    immgen_pipe #(.XLEN(32), .SIGN_EXT(0), .BYTE_OFFSET(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .instr(instr), .out_valid(out_valid_v[1]), .out_ready(out_ready), .imm(imm_b),
        .fmt(fmt_b), .illegal(ill_v[1]));
    immgen_pipe #(.XLEN(64), .SIGN_EXT(1), .BYTE_OFFSET(0)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .instr(instr), .out_valid(out_valid_v[2]), .out_ready(out_ready), .imm(imm_c),
        .fmt(fmt_c), .illegal(ill_v[2]));

    initial forever #5 clk = ~clk;

    // Immediate value as a signed integer built from the instruction fields.
    function automatic res_t model(input int xlen, input bit sx, input bit bo, input logic [31:0] ins);
        res_t   r;
        longint v;
        int     w;
        bit     do_sx;
        r.fmt = 3'd0;
        r.ill = 1'b1;
        r.imm = 64'd0;
        v = 0;
        w = 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: begin r.fmt = 3'd1; v = longint'(ins[31:20]); w = 12; end
            7'h1B: if (xlen == 64) begin r.fmt = 3'd1; v = longint'(ins[31:20]); w = 12; end
            7'h23: begin r.fmt = 3'd2; v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); w = 12; end
            7'h63: begin
                r.fmt = 3'd3;
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                w = 13;
            end
            7'h37, 7'h17: begin r.fmt = 3'd4; v = longint'(ins[31:12]) * 4096; w = 32; end
            7'h6F: begin
                r.fmt = 3'd5;
                v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                w = 21;
            end
            default: ;
        endcase
        if (r.fmt != 3'd0) begin
            r.ill = 1'b0;
            if ((r.fmt == 3'd3 || r.fmt == 3'd5) && !bo) begin
                v = v / 2;
                w = w - 1;
            end
            do_sx = sx || (r.fmt == 3'd4 && xlen == 64);
            if (ins[31] && do_sx) v = v - (longint'(1) << w);
            r.imm = (xlen == 32) ? (64'(v) & 64'h0000_0000_FFFF_FFFF) : 64'(v);
        end
        return r;
    endfunction

    function automatic entry_t mk_entry(input logic [31:0] ins, input int t);
        entry_t e;
        e.r0 = model(64, 1'b1, 1'b1, ins);
        e.r1 = model(32, 1'b0, 1'b0, ins);
        e.r2 = model(64, 1'b1, 1'b0, ins);
        e.t  = t;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 9))
            0: r[6:0] = 7'h03;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h67;
            3: r[6:0] = 7'h1B;
            4: r[6:0] = 7'h23;
            5: r[6:0] = 7'h63;
            6: r[6:0] = 7'h37;
            7: r[6:0] = 7'h17;
            8: r[6:0] = 7'h6F;
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string name, input logic [63:0] o_imm, input logic [2:0] o_fmt,
                           input logic o_ill, input res_t e);
        chk({name, "_imm"}, o_imm, e.imm);
        chk({name, "_fmt"}, 64'(o_fmt), 64'(e.fmt));
        chk({name, "_illegal"}, 64'(o_ill), 64'(e.ill));
    endtask

    // One clock: check at negedge against the scoreboard, update it at posedge.
    task automatic cycle();
        bit ev, eir, fire_in, fire_out;
        @(negedge clk);
        ev  = (exp_q.size() > 0) && (cyc - exp_q[0].t >= 2);
        eir = (exp_q.size() < 2) || out_ready;
        chk("in_ready", 64'(in_ready_v), eir ? 64'd7 : 64'd0);
        chk("out_valid", 64'(out_valid_v), ev ? 64'd7 : 64'd0);
        if (ev) begin
            chk_res("a", imm_a, fmt_a, ill_v[0], exp_q[0].r0);
            chk_res("b", {32'b0, imm_b}, fmt_b, ill_v[1], exp_q[0].r1);
            chk_res("c", imm_c, fmt_c, ill_v[2], exp_q[0].r2);
        end
        if (out_valid_v[0] && out_ready && !flush) dut_drained++;
        fire_in  = in_valid && eir && !flush;
        fire_out = ev && out_ready && !flush;
        acc = fire_in;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (fire_out) void'(exp_q.pop_front());
            if (fire_in) exp_q.push_back(mk_entry(instr, cyc));
        end
        cyc++;
        #1;
    endtask

    task automatic send_one(input logic [31:0] ins, input logic [63:0] e_a, input logic [63:0] e_b,
                            input logic [63:0] e_c, input logic [2:0] e_fmt, input logic e_ill);
        instr = ins;
        in_valid = 1'b1;
        out_ready = 1'b1;
        flush = 1'b0;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("k_out_valid", 64'(out_valid_v), 64'd7);
        chk("k_imm_a", imm_a, e_a);
        chk("k_imm_b", {32'b0, imm_b}, e_b);
        chk("k_imm_c", imm_c, e_c);
        chk("k_fmt", 64'(fmt_a), 64'(e_fmt));
        chk("k_illegal", 64'(ill_v[0]), 64'(e_ill));
        cycle();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
    endtask

    logic [31:0] stream [4];
    int idx;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        instr = 32'd0;
        #12;
        chk("rst_out_valid", 64'(out_valid_v), 64'd0);
        chk("rst_imm_a", imm_a, 64'd0);
        chk("rst_imm_b", {32'b0, imm_b}, 64'd0);
        chk("rst_fmt", 64'(fmt_a), 64'd0);
        chk("rst_illegal", 64'(ill_v), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        // Known vectors
        send_one(32'hFFC12083, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0FFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0);
        send_one(32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0000_0FFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
        send_one(32'h123452B7, 64'h0000_0000_1234_5000, 64'h1234_5000, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
        send_one(32'h0010006F, 64'h800, 64'h400, 64'h400, 3'd5, 1'b0);
        send_one(32'h0000007F, 64'd0, 64'd0, 64'd0, 3'd0, 1'b1);
        send_one(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        send_one(32'h80002023, 64'hFFFF_FFFF_FFFF_F800, 64'h0000_0800, 64'hFFFF_FFFF_FFFF_F800, 3'd2, 1'b0);
        send_one(32'hFFF0001B, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);

        // Four-beat stream with a three-cycle consumer stall
        stream[0] = 32'h00410093;
        stream[1] = 32'hFE000CE3;
        stream[2] = 32'h123452B7;
        stream[3] = 32'h0010006F;
        idx = 0;
        dut_drained = 0;
        for (int k = 0; k < 12; k++) begin
            out_ready = !(k >= 2 && k <= 4);
            in_valid = (idx < 4);
            instr = stream[(idx < 4) ? idx : 3];
            cycle();
            if (acc) idx++;
        end
        drain();
        chk("stream_accepted", 64'(idx), 64'd4);
        chk("stream_drained", 64'(dut_drained), 64'd4);

        // Flush with two in flight; the instruction presented with flush is dropped
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'hFFC12083;
        cycle();
        instr = 32'h0010006F;
        cycle();
        flush = 1'b1;
        instr = 32'h123452B7;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid_v), 64'd0);
        out_ready = 1'b1;
        cycle();
        send_one(32'hFFC12083, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0FFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'hFE000CE3;
        cycle();
        instr = 32'h800000B7;
        cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid_v), 64'd0);
        chk("arst_imm_a", imm_a, 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        send_one(32'h0010006F, 64'h800, 64'h400, 64'h400, 3'd5, 1'b0);

        // Random traffic with random back-pressure and occasional flush
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 49) == 0);
            instr = rand_instr();
            cycle();
        end
        drain();
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
